// File: rtl/spi_frame_pkg.sv
// Shared types and constants for the SPI message framer: state encoding,
// header field layout and the widths used by the framer and its skid buffer.
package spi_frame_pkg;

  localparam int WORD_W = 16;
  localparam int LEN_W  = 8;

  localparam logic [7:0] SYNC_DEFAULT   = 8'hA5;
  localparam logic [7:0] SRC_ID_DEFAULT = 8'h01;

  localparam int HDR_SYNC_MSB = 15;
  localparam int HDR_SYNC_LSB = 8;
  localparam int HDR_SRC_MSB  = 7;
  localparam int HDR_SRC_LSB  = 0;
  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 0;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN     = 3'd1,
    S_HDR0    = 3'd2,
    S_HDR1    = 3'd3,
    S_PAYLOAD = 3'd4,
    S_TRAIL   = 3'd5,
    S_GAP     = 3'd6
  } state_t;

  function automatic logic [WORD_W-1:0] make_hdr0(input logic [7:0] sync,
                                                   input logic [7:0] src);
    logic [WORD_W-1:0] w;
    w = '0;
    w[HDR_SYNC_MSB:HDR_SYNC_LSB] = sync;
    w[HDR_SRC_MSB:HDR_SRC_LSB]   = src;
    return w;
  endfunction

  function automatic logic [WORD_W-1:0] make_hdr1(input logic [LEN_W-1:0] len);
    logic [WORD_W-1:0] w;
    w = '0;
    w[HDR_LEN_MSB:HDR_LEN_LSB] = len;
    return w;
  endfunction

endpackage

// File: rtl/spi_msg_framer_if.sv
// Bundle of the framer's upstream (SPI input FIFO) and downstream (word
// stream) signals; master is the framer, slave is its environment.
interface spi_msg_framer_if;
  import spi_frame_pkg::*;

  logic              GOT_FULL_MSG;
  logic [LEN_W-1:0]  MSG_LEN;
  logic [WORD_W-1:0] FIFO_Q;
  logic              MSG_START;
  logic              RD_REQ;
  logic [WORD_W-1:0] OUT_DATA;
  logic              OUT_VALID;
  logic              OUT_READY;
  logic              OUT_SOP;
  logic              OUT_EOP;
  logic              BUSY;

  modport master (
    input  GOT_FULL_MSG, MSG_LEN, FIFO_Q, OUT_READY,
    output MSG_START, RD_REQ, OUT_DATA, OUT_VALID, OUT_SOP, OUT_EOP, BUSY
  );

  modport slave (
    output GOT_FULL_MSG, MSG_LEN, FIFO_Q, OUT_READY,
    input  MSG_START, RD_REQ, OUT_DATA, OUT_VALID, OUT_SOP, OUT_EOP, BUSY
  );

endinterface

// File: rtl/framer_skid_buf.sv
// Two-entry FIFO holding prefetched payload words; the framer's read-request
// throttle guarantees it is never pushed while full or popped while empty.
module framer_skid_buf
  import spi_frame_pkg::*;
(
  input  logic              SYS_CLK,
  input  logic              RST,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [WORD_W-1:0] i_data,
  output logic [WORD_W-1:0] o_head,
  output logic [1:0]        o_occ
);

  logic [WORD_W-1:0] r_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_occ;

  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_head = r_mem[r_rd_ptr];
  assign o_occ  = r_occ;

endmodule

// File: rtl/spi_msg_framer.sv
// Drains one message from the SPI input FIFO and emits it as a frame:
// two header words, the payload, then a 16-bit additive checksum trailer.
module spi_msg_framer
  import spi_frame_pkg::*;
#(
  parameter logic [7:0] SRC_ID  = SRC_ID_DEFAULT,
  parameter logic [7:0] SYNC    = SYNC_DEFAULT,
  parameter int unsigned MIN_GAP = 4
) (
  input logic RST,
  input logic SYS_CLK,
  spi_msg_framer_if.master bus
);

  localparam logic [LEN_W-1:0] GAP_LOAD = LEN_W'(MIN_GAP);

  state_t            r_state;
  logic              r_msg_start;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_rd_cnt;
  logic [LEN_W-1:0]  r_wr_cnt;
  logic [LEN_W-1:0]  r_gap_cnt;
  logic [WORD_W-1:0] r_sum;
  logic              r_inflight;

  logic [WORD_W-1:0] w_head;
  logic [1:0]        w_occ;
  logic              w_out_valid;
  logic [WORD_W-1:0] w_out_data;
  logic              w_out_sop;
  logic              w_out_eop;
  logic              w_hs;
  logic              w_pop;
  logic              w_rd_req;

  framer_skid_buf u_skid (
    .SYS_CLK (SYS_CLK),
    .RST     (RST),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_data  (bus.FIFO_Q),
    .o_head  (w_head),
    .o_occ   (w_occ)
  );

  always_comb begin
    w_out_valid = 1'b0;
    w_out_data  = '0;
    w_out_sop   = 1'b0;
    w_out_eop   = 1'b0;
    case (r_state)
      S_HDR0: begin
        w_out_valid = 1'b1;
        w_out_data  = make_hdr0(SYNC, SRC_ID);
        w_out_sop   = 1'b1;
      end
      S_HDR1: begin
        w_out_valid = 1'b1;
        w_out_data  = make_hdr1(r_len);
      end
      S_PAYLOAD: begin
        w_out_valid = (w_occ != 2'd0);
        w_out_data  = w_head;
      end
      S_TRAIL: begin
        w_out_valid = 1'b1;
        w_out_data  = r_sum;
        w_out_eop   = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_hs  = w_out_valid && bus.OUT_READY;
  assign w_pop = (r_state == S_PAYLOAD) && w_hs;

  // Keep buffered + in-flight words below two after this cycle's pop, so the
  // two-entry buffer can always absorb the word answering this request.
  assign w_rd_req = (r_state inside {S_HDR0, S_HDR1, S_PAYLOAD}) &&
                    (r_rd_cnt != '0) &&
                    (({1'b0, w_occ} + {2'b00, r_inflight}) < (3'd2 + {2'b00, w_pop}));

  always_ff @(posedge SYS_CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= S_IDLE;
      r_msg_start <= 1'b0;
      r_len       <= '0;
      r_rd_cnt    <= '0;
      r_wr_cnt    <= '0;
      r_gap_cnt   <= GAP_LOAD;
      r_sum       <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_msg_start <= 1'b0;
      r_inflight  <= w_rd_req;
      if (w_rd_req) begin
        r_rd_cnt <= r_rd_cnt - 1'b1;
      end
      if (w_hs && (r_state != S_TRAIL)) begin
        r_sum <= r_sum + w_out_data;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.GOT_FULL_MSG) begin
            r_msg_start <= 1'b1;
            r_state     <= S_LEN;
          end
        end
        // First LEN cycle carries MSG_START; the length is valid one cycle later.
        S_LEN: begin
          if (!r_msg_start) begin
            r_len    <= bus.MSG_LEN;
            r_rd_cnt <= bus.MSG_LEN;
            r_wr_cnt <= bus.MSG_LEN;
            r_sum    <= '0;
            r_state  <= (bus.MSG_LEN == '0) ? S_IDLE : S_HDR0;
          end
        end
        S_HDR0: begin
          if (w_hs) r_state <= S_HDR1;
        end
        S_HDR1: begin
          if (w_hs) r_state <= S_PAYLOAD;
        end
        S_PAYLOAD: begin
          if (w_pop) begin
            r_wr_cnt <= r_wr_cnt - 1'b1;
            if (r_wr_cnt == LEN_W'(1)) r_state <= S_TRAIL;
          end
        end
        S_TRAIL: begin
          if (w_hs) begin
            r_state   <= S_GAP;
            r_gap_cnt <= GAP_LOAD;
          end
        end
        // The IDLE cycle that follows also counts toward the enforced gap.
        S_GAP: begin
          if (r_gap_cnt <= LEN_W'(2)) r_state <= S_IDLE;
          else r_gap_cnt <= r_gap_cnt - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.MSG_START = r_msg_start;
  assign bus.RD_REQ    = w_rd_req;
  assign bus.OUT_DATA  = w_out_data;
  assign bus.OUT_VALID = w_out_valid;
  assign bus.OUT_SOP   = w_out_sop;
  assign bus.OUT_EOP   = w_out_eop;
  assign bus.BUSY      = (r_state != S_IDLE);

endmodule
